// File: rtl/ip_tx_tile_defs.sv
// Shared definitions for the IP TX tile ingress path: widths, NoC header and
// metadata flit layouts, and the ingress FSM state encoding.
package ip_tx_tile_defs;

  localparam int NOC_DATA_WIDTH  = 512;
  localparam int MAC_INTERFACE_W = 512;
  localparam int IP_ADDR_W       = 32;
  localparam int TOT_LEN_W       = 16;
  localparam int PROTOCOL_W      = 8;
  localparam int MAC_PADBYTES_W  = 6;
  localparam int MSG_TIMESTAMP_W = 64;
  localparam int MSG_LEN_W       = 16;
  localparam int FLIT_CNT_W      = 11;
  localparam int PAYLOAD_BYTES   = 64;
  localparam int NOC_HDR_W       = 64;
  localparam int META_W          = 152;

  // NoC header, occupying the top NOC_HDR_W bits of flit 0.
  typedef struct packed {
    logic [13:0]          dst_chip;
    logic [7:0]           dst_x;
    logic [7:0]           dst_y;
    logic [3:0]           fbits;
    logic [MSG_LEN_W-1:0] msg_len;   // flits following the header
    logic [7:0]           msg_type;
    logic [5:0]           rsvd;
  } noc_hdr_flit_t;

  // Send-request metadata, occupying the top META_W bits of flit 1.
  typedef struct packed {
    logic [IP_ADDR_W-1:0]       src_ip;
    logic [IP_ADDR_W-1:0]       dst_ip;
    logic [TOT_LEN_W-1:0]       data_len;
    logic [PROTOCOL_W-1:0]      protocol;
    logic [MSG_TIMESTAMP_W-1:0] timestamp;
  } ip_tx_meta_flit_t;

  typedef enum logic [1:0] {
    RD_HDR  = 2'd0,
    RD_META = 2'd1,
    HDR_OUT = 2'd2,
    DATA    = 2'd3
  } ip_tx_in_state_e;

endpackage

// File: rtl/ip_tx_len_calc.sv
// Payload flit count and trailing pad bytes derived from the byte length.
// Purely combinational.
module ip_tx_len_calc
  import ip_tx_tile_defs::*;
(
  input  logic [TOT_LEN_W-1:0]      data_len_i,
  output logic [FLIT_CNT_W-1:0]     payload_flits_o,
  output logic [MAC_PADBYTES_W-1:0] padbytes_o
);

  // Ceiling division by 64 done in 17 bits so 0xFFFF does not wrap.
  assign payload_flits_o = FLIT_CNT_W'(({1'b0, data_len_i} + 17'd63) >> 6);

  // A length that is a multiple of 64 fills the last flit completely.
  assign padbytes_o = MAC_PADBYTES_W'(7'(PAYLOAD_BYTES) - {1'b0, data_len_i[5:0]});

endmodule

// File: rtl/ip_tx_noc_in.sv
// IP TX tile NoC ingress: header flit + metadata flit -> one header
// transaction, then payload flits passed straight through with last/padbytes.
// Optional macro IP_TX_IN_LEN_CHECK_EN enables the sticky msg_len check.
module ip_tx_noc_in
  import ip_tx_tile_defs::*;
#(
  parameter int DATA_W = NOC_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       noc0_ctovr_ip_tx_in_val,
  input  logic [DATA_W-1:0]          noc0_ctovr_ip_tx_in_data,
  output logic                       ip_tx_in_noc0_ctovr_rdy,
  output logic                       ip_tx_in_ip_to_stream_hdr_val,
  output logic [IP_ADDR_W-1:0]       ip_tx_in_ip_to_stream_src_ip,
  output logic [IP_ADDR_W-1:0]       ip_tx_in_ip_to_stream_dst_ip,
  output logic [TOT_LEN_W-1:0]       ip_tx_in_ip_to_stream_data_len,
  output logic [PROTOCOL_W-1:0]      ip_tx_in_ip_to_stream_protocol,
  output logic [MSG_TIMESTAMP_W-1:0] ip_tx_in_ip_to_stream_timestamp,
  input  logic                       ip_to_stream_ip_tx_in_hdr_rdy,
  output logic                       ip_tx_in_ip_to_stream_data_val,
  output logic [DATA_W-1:0]          ip_tx_in_ip_to_stream_data,
  output logic                       ip_tx_in_ip_to_stream_data_last,
  output logic [MAC_PADBYTES_W-1:0]  ip_tx_in_ip_to_stream_data_padbytes,
  input  logic                       ip_to_stream_ip_tx_in_data_rdy,
  output logic                       ip_tx_in_len_err
);

  ip_tx_in_state_e            state_q;
  logic [IP_ADDR_W-1:0]       src_ip_q;
  logic [IP_ADDR_W-1:0]       dst_ip_q;
  logic [TOT_LEN_W-1:0]       data_len_q;
  logic [PROTOCOL_W-1:0]      protocol_q;
  logic [MSG_TIMESTAMP_W-1:0] timestamp_q;
  logic [MAC_PADBYTES_W-1:0]  pad_q;
  logic [FLIT_CNT_W-1:0]      cnt_q;

  ip_tx_meta_flit_t           meta_flit;
  logic [FLIT_CNT_W-1:0]      meta_flits;
  logic [MAC_PADBYTES_W-1:0]  meta_pad;
  logic                       in_data;
  logic                       is_last;

  assign meta_flit = noc0_ctovr_ip_tx_in_data[DATA_W-1 -: META_W];

  ip_tx_len_calc u_len_calc (
    .data_len_i      (meta_flit.data_len),
    .payload_flits_o (meta_flits),
    .padbytes_o      (meta_pad)
  );

`ifdef IP_TX_IN_LEN_CHECK_EN
  noc_hdr_flit_t        hdr_flit;
  logic [MSG_LEN_W-1:0] msg_len_q;
  logic                 len_err_q;
  logic                 unused_hdr_bits;

  assign hdr_flit        = noc0_ctovr_ip_tx_in_data[DATA_W-1 -: NOC_HDR_W];
  assign unused_hdr_bits = ^{hdr_flit.dst_chip, hdr_flit.dst_x, hdr_flit.dst_y,
                             hdr_flit.fbits, hdr_flit.msg_type, hdr_flit.rsvd};
  assign ip_tx_in_len_err = len_err_q;
`else
  assign ip_tx_in_len_err = 1'b0;
`endif

  // Handshake outputs are gated by reset so nothing is accepted or offered
  // while the block is being reset.
  assign in_data = rst && (state_q == DATA);
  assign is_last = in_data && (cnt_q == FLIT_CNT_W'(1));

  assign ip_tx_in_noc0_ctovr_rdy = rst && ((state_q == RD_HDR) || (state_q == RD_META) ||
                                           (in_data && ip_to_stream_ip_tx_in_data_rdy));

  assign ip_tx_in_ip_to_stream_hdr_val   = rst && (state_q == HDR_OUT);
  assign ip_tx_in_ip_to_stream_src_ip    = src_ip_q;
  assign ip_tx_in_ip_to_stream_dst_ip    = dst_ip_q;
  assign ip_tx_in_ip_to_stream_data_len  = data_len_q;
  assign ip_tx_in_ip_to_stream_protocol  = protocol_q;
  assign ip_tx_in_ip_to_stream_timestamp = timestamp_q;

  // Payload is a zero-latency pass-through of the NoC flit.
  assign ip_tx_in_ip_to_stream_data_val      = in_data && noc0_ctovr_ip_tx_in_val;
  assign ip_tx_in_ip_to_stream_data          = noc0_ctovr_ip_tx_in_data;
  assign ip_tx_in_ip_to_stream_data_last     = is_last;
  assign ip_tx_in_ip_to_stream_data_padbytes = is_last ? pad_q : '0;

  // Message FSM: header flit, metadata flit, header offer, payload stream.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RD_HDR;
      src_ip_q    <= '0;
      dst_ip_q    <= '0;
      data_len_q  <= '0;
      protocol_q  <= '0;
      timestamp_q <= '0;
      pad_q       <= '0;
      cnt_q       <= '0;
`ifdef IP_TX_IN_LEN_CHECK_EN
      msg_len_q   <= '0;
      len_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        RD_HDR: begin
          if (noc0_ctovr_ip_tx_in_val) begin
`ifdef IP_TX_IN_LEN_CHECK_EN
            msg_len_q <= hdr_flit.msg_len;
`endif
            state_q <= RD_META;
          end
        end
        RD_META: begin
          if (noc0_ctovr_ip_tx_in_val) begin
            src_ip_q    <= meta_flit.src_ip;
            dst_ip_q    <= meta_flit.dst_ip;
            data_len_q  <= meta_flit.data_len;
            protocol_q  <= meta_flit.protocol;
            timestamp_q <= meta_flit.timestamp;
            pad_q       <= meta_pad;
            cnt_q       <= meta_flits;
`ifdef IP_TX_IN_LEN_CHECK_EN
            // Length is still taken from data_len; the flag only reports.
            if (msg_len_q != MSG_LEN_W'(meta_flits) + MSG_LEN_W'(1)) begin
              len_err_q <= 1'b1;
            end
`endif
            state_q <= HDR_OUT;
          end
        end
        HDR_OUT: begin
          if (ip_to_stream_ip_tx_in_hdr_rdy) begin
            state_q <= (cnt_q != '0) ? DATA : RD_HDR;
          end
        end
        DATA: begin
          if (noc0_ctovr_ip_tx_in_val && ip_to_stream_ip_tx_in_data_rdy) begin
            cnt_q <= cnt_q - FLIT_CNT_W'(1);
            if (cnt_q == FLIT_CNT_W'(1)) begin
              state_q <= RD_HDR;
            end
          end
        end
        default: state_q <= RD_HDR;
      endcase
    end
  end

endmodule

// File: doc/ip_tx_noc_in.md
# ip_tx_noc_in

Ingress deserializer of the IP TX tile, directly downstream of the UDP TX tile's NoC output path. Consumes val/rdy NoC flits (after credit-to-val/rdy conversion) carrying one IP-level send request: NoC header flit, metadata flit, payload flits. Emits a single header transaction (src/dst IP, payload length, protocol, timestamp) followed by a framed payload stream with last/padbytes toward the IP-to-stream stage.

## Interface
- DATA_W, default `NOC_DATA_WIDTH` (512): flit and payload width; must equal `MAC_INTERFACE_W`.
- clk  in  1  clock
- rst  in  1  reset; **synchronous, active-low** (block in reset while rst==0)
- noc0_ctovr_ip_tx_in_val  in  1  flit valid
- noc0_ctovr_ip_tx_in_data  in  DATA_W  flit
- ip_tx_in_noc0_ctovr_rdy  out  1  flit ready
- ip_tx_in_ip_to_stream_hdr_val  out  1  header valid
- ip_tx_in_ip_to_stream_src_ip  out  `IP_ADDR_W`  source IP
- ip_tx_in_ip_to_stream_dst_ip  out  `IP_ADDR_W`  destination IP
- ip_tx_in_ip_to_stream_data_len  out  `TOT_LEN_W`  payload bytes
- ip_tx_in_ip_to_stream_protocol  out  `PROTOCOL_W`  IP protocol
- ip_tx_in_ip_to_stream_timestamp  out  MSG_TIMESTAMP_W  timestamp
- ip_to_stream_ip_tx_in_hdr_rdy  in  1  header ready
- ip_tx_in_ip_to_stream_data_val  out  1  payload valid
- ip_tx_in_ip_to_stream_data  out  DATA_W  payload
- ip_tx_in_ip_to_stream_data_last  out  1  final payload flit
- ip_tx_in_ip_to_stream_data_padbytes  out  `MAC_PADBYTES_W`  invalid trailing bytes (last only)
- ip_to_stream_ip_tx_in_data_rdy  in  1  payload ready
- ip_tx_in_len_err  out  1  sticky length-mismatch flag

## Operation
- Flit 0: NoC header, decoded via the shared NoC header struct; only msg_len (flits following) is used.
- Flit 1: metadata, packed from MSB: src_ip[31:0], dst_ip[31:0], data_len[15:0], protocol[7:0], timestamp[63:0]; rest ignored.
- Flits 2..: payload, byte 0 at MSB.
- payload_flits = (data_len + 63) >> 6, computed in 17 bits; 0..1024, counter 11 bits.
- padbytes on last = (64 − data_len[5:0]) mod 64; 0 on non-last flits.
- FSM:
  - RD_HDR: rdy=1; on val, latch msg_len → RD_META.
  - RD_META: rdy=1; on val, latch metadata, load counter=payload_flits → HDR_OUT.
  - HDR_OUT: rdy=0, hdr_val=1, fields stable from registers; on hdr_rdy → DATA if payload_flits>0 else RD_HDR.
  - DATA: combinational pass-through: data_val=noc val, noc rdy=data_rdy, data=flit; last = (counter==1); each handshake decrements; last handshake → RD_HDR.
- Header always fully accepted before any payload flit is presented.
- data_len=0: no payload state; message ends at header handshake.

## Timing
- Reset (rst==0 at posedge): state=RD_HDR; all val outputs 0; header/padbytes registers 0; len_err 0; rdy 0 during reset cycle.
- hdr_val asserts the cycle after the metadata handshake; header latency 2 cycles from flit 0 acceptance with no stalls.
- Payload path zero-latency (combinational val/rdy/data); no buffering.
- Minimum occupancy: 3 cycles + payload_flits per message; back-to-back messages need no idle cycle.
- val must not depend on rdy; outputs hold while val && !rdy.
- Reset mid-message discards all state; partial flits from upstream after reset are treated as a new header (upstream resets together).

## Configuration
- `IP_TX_IN_LEN_CHECK_EN` defined: in RD_META, if msg_len != payload_flits + 1, set len_err (sticky until reset); message is still forwarded using data_len.
- Undefined: no comparison; len_err tied 0; msg_len register not synthesized.

## Structure
- Shared package (ip_tx_tile_defs): metadata flit struct, MSG_TIMESTAMP_W, FSM state enum, payload-byte constant 64.
- Single module; flit-count/padbytes arithmetic optionally in submodule ip_tx_len_calc (pure combinational).

## Test plan
- data_len=100, 2 payload flits, rdy always 1 → one header (len 100), flits with last on 2nd, padbytes=28.
- data_len=64 → one flit, last=1, padbytes=0; data_len=65 → two flits, padbytes=63.
- data_len=0 → header only, no data_val; next message's flit 0 accepted next cycle.
- hdr_rdy held 0 for 5 cycles, then random data_rdy toggling → outputs stable while stalled, noc rdy=0 in HDR_OUT, no flit lost/duplicated.
- With macro: msg_len=5, data_len=100 → len_err=1 and stays 1; without macro → len_err=0.
- rst=0 asserted mid-DATA → next cycle all vals 0, state RD_HDR; fresh message then processed correctly.
